// File: rtl/cic_pkg.sv
// Shared constants and width helper for the CIC decimator.
package cic_pkg;

    localparam int CIC_N  = 3;
    localparam int CIC_R  = 64;
    localparam int CIC_IW = 2;

    // Bit growth of an N-stage, M=1 CIC with ratio R: the full-scale DC gain R^N
    // must fit without overflow, so the register width is IW + N*ceil(log2(R)).
    function automatic int cic_out_width(input int iw, input int n, input int r);
        return iw + n * $clog2(r);
    endfunction

endpackage

// File: rtl/cic_decimator_channel.sv
// One CIC channel: N integrators at the input rate, N combs (M=1) evaluated on strobe.
module cic_channel
    import cic_pkg::*;
#(
    parameter int N  = CIC_N,
    parameter int IW = CIC_IW,
    parameter int OW = cic_out_width(CIC_IW, CIC_N, CIC_R)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 strobe,
    input  logic signed [IW-1:0] x,
    output logic signed [OW-1:0] y
);

    // All arithmetic is modulo 2^OW; wrap-around in the integrators is cancelled by the combs.
    logic [N-1:0][OW-1:0] integ;
    logic [N-1:0][OW-1:0] dly;
    logic [N-1:0][OW-1:0] comb_in;
    logic [OW-1:0]        comb_out;
    logic [OW-1:0]        x_ext;

    assign x_ext = {{(OW-IW){x[IW-1]}}, x};

    // Integrator cascade: each stage accumulates the registered value of the previous one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            integ <= '0;
        end else begin
            integ[0] <= integ[0] + x_ext;
            for (int k = 1; k < N; k++)
                integ[k] <= integ[k] + integ[k-1];
        end
    end

    // Comb chain is purely combinational from the last integrator; comb_in[k] is x_k of stage k.
    always_comb begin
        comb_out = integ[N-1];
        comb_in  = '0;
        for (int k = 0; k < N; k++) begin
            comb_in[k] = comb_out;
            comb_out   = comb_out - dly[k];
        end
    end

    // On the decimation strobe, latch comb delays and register the filter output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly <= '0;
            y   <= '0;
        end else if (strobe) begin
            dly <= comb_in;
            y   <= comb_out;
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// Dual-channel (I/Q) CIC decimator sharing one decimation counter and valid strobe.
module cic_decimator
    import cic_pkg::*;
#(
    parameter  int N  = CIC_N,
    parameter  int R  = CIC_R,
    parameter  int IW = CIC_IW,
    localparam int OW = cic_out_width(IW, N, R)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [IW-1:0] I,
    input  logic signed [IW-1:0] Q,
    output logic signed [OW-1:0] I_dec,
    output logic signed [OW-1:0] Q_dec,
    output logic                 dec_valid
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;

    logic [CW-1:0] cnt;
    logic          strobe;

    assign strobe = (cnt == CW'(R - 1));

    // Decimation counter 0..R-1 and the one-cycle valid pulse aligned with the output update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            dec_valid <= 1'b0;
        end else begin
            cnt       <= strobe ? '0 : cnt + 1'b1;
            dec_valid <= strobe;
        end
    end

    cic_channel #(.N(N), .IW(IW), .OW(OW)) u_ch_i (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .x      (I),
        .y      (I_dec)
    );

    cic_channel #(.N(N), .IW(IW), .OW(OW)) u_ch_q (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .x      (Q),
        .y      (Q_dec)
    );

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench: directed phases plus random I/Q against a direct-form FIR model of the CIC.
module tb_cic_decimator;

    localparam int N  = 3;
    localparam int R  = 64;
    localparam int IW = 2;
    localparam int OW = 20;
    localparam int HL = N * (R - 1) + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [IW-1:0] I, Q;
    logic signed [OW-1:0] I_dec, Q_dec;
    logic                 dec_valid;

    always #5 clk = ~clk;

    cic_decimator dut (
        .clk       (clk),
        .reset     (reset),
        .I         (I),
        .Q         (Q),
        .I_dec     (I_dec),
        .Q_dec     (Q_dec),
        .dec_valid (dec_valid)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Impulse response of (1 + z^-1 + ... + z^-(R-1))^N
    longint h [HL];
    int     xi[$];
    int     xq[$];
    int     t;
    int     nvalid;
    logic signed [OW-1:0] exp_i, exp_q;

    // Optional constant-output expectation from the cfrom-th valid onward.
    bit                   cen;
    int                   cfrom;
    logic signed [OW-1:0] ci, cq;

    // Settling-sequence capture (1) and replay comparison (2).
    int                   rec_mode;
    logic signed [OW-1:0] rec_i[6], rec_q[6];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic signed [OW-1:0] fir(input int sel, input int tt);
        longint s;
        s = 0;
        for (int j = 0; j < HL; j++) begin
            int idx;
            idx = tt - N - j;
            if (idx >= 0)
                s += h[j] * longint'(sel == 0 ? xi[idx] : xq[idx]);
        end
        return s[OW-1:0];
    endfunction

    task automatic step(input int iv, input int qv);
        bit sv;
        I = 2'(iv);
        Q = 2'(qv);
        xi.push_back(iv);
        xq.push_back(qv);
        @(posedge clk);
        #1;
        sv = ((t % R) == R - 1);
        chk("dec_valid", 32'(dec_valid), 32'(sv));
        if (sv) begin
            exp_i = fir(0, t);
            exp_q = fir(1, t);
            nvalid++;
        end
        chk("I_dec_model", 32'(I_dec), 32'(exp_i));
        chk("Q_dec_model", 32'(Q_dec), 32'(exp_q));
        if (sv && cen && nvalid >= cfrom) begin
            chk("I_dec_const", 32'(I_dec), 32'(ci));
            chk("Q_dec_const", 32'(Q_dec), 32'(cq));
        end
        if (sv && nvalid <= 6) begin
            if (rec_mode == 1) begin
                rec_i[nvalid-1] = I_dec;
                rec_q[nvalid-1] = Q_dec;
            end else if (rec_mode == 2) begin
                chk("settle_I", 32'(I_dec), 32'(rec_i[nvalid-1]));
                chk("settle_Q", 32'(Q_dec), 32'(rec_q[nvalid-1]));
            end
        end
        t++;
    endtask

    // Assert reset (asynchronously, mid-cycle), verify outputs clear at once, hold, release.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", 32'(dec_valid), 32'sd0);
        chk("rst_I",     32'(I_dec),     32'sd0);
        chk("rst_Q",     32'(Q_dec),     32'sd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        xi.delete();
        xq.delete();
        t        = 0;
        nvalid   = 0;
        exp_i    = '0;
        exp_q    = '0;
        cen      = 1'b0;
        rec_mode = 0;
    endtask

    initial begin
        longint a[HL], b[HL];

        // Build the reference impulse response by repeated boxcar convolution.
        for (int k = 0; k < HL; k++) a[k] = 0;
        a[0] = 1;
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < HL; k++) begin
                b[k] = 0;
                for (int j = 0; j < R; j++)
                    if (k - j >= 0) b[k] += a[k-j];
            end
            a = b;
        end
        h = a;

        reset = 1'b1;
        I = '0;
        Q = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Zero input: every output zero, first pulse on the 64th clk.
        cen = 1'b1; cfrom = 1; ci = '0; cq = '0;
        for (int k = 0; k < 2000; k++) step(0, 0);

        // DC +1 / -1, also capturing the settling sequence.
        do_reset();
        cen = 1'b1; cfrom = N + 1; ci = 20'sd262144; cq = -20'sd262144; rec_mode = 1;
        for (int k = 0; k < 1000; k++) step(1, -1);

        // Full-scale negative over a long run to exercise integrator wrap.
        do_reset();
        cen = 1'b1; cfrom = N + 1; ci = -20'sd524288; cq = -20'sd524288;
        for (int k = 0; k < 20000; k++) step(-2, -2);

        // Nyquist tone on I lands in a CIC null.
        do_reset();
        cen = 1'b1; cfrom = N + 1; ci = '0; cq = '0;
        for (int k = 0; k < 2000; k++) step((k % 2 == 0) ? 1 : -1, 0);

        // Reset in the middle of a decimation period, then the DC settling must repeat.
        do_reset();
        for (int k = 0; k < 150; k++) step(1, -1);
        do_reset();
        cen = 1'b1; cfrom = N + 1; ci = 20'sd262144; cq = -20'sd262144; rec_mode = 2;
        for (int k = 0; k < 600; k++) step(1, -1);

        // Random 2-bit I/Q against the reference model.
        do_reset();
        for (int k = 0; k < 50000; k++)
            step(int'($urandom_range(0, 3)) - 2, int'($urandom_range(0, 3)) - 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Dual-channel (I/Q) CIC decimation filter directly downstream of iq_modulator.
- Consumes the 2-bit signed I/Q mixer products at the full sampling clock rate (2^18 kHz).
- Produces wide, decimated baseband I/Q samples with a one-cycle valid strobe for the following channel-filter/demodulator stages.
- Architecture: N integrators at clk rate, a decimation counter, N combs (differential delay M=1) at the output rate.

Parameters:
- N, 3, number of integrator/comb stages; legal range 1..6.
- R, 64, decimation ratio; legal range 2..1024; any integer.
- IW, 2, input sample width (signed).
- OW, IW + N*$clog2(R) = 20, output and internal register width (signed); derived, not overridden.

Ports:
- clk  input  1  sampling clock, same clock as iq_modulator.
- reset  input  1  asynchronous, active-high reset.
- I  input  IW  signed in-phase sample, one per clk.
- Q  input  IW  signed quadrature sample, one per clk.
- I_dec  output  OW  signed decimated in-phase sample.
- Q_dec  output  OW  signed decimated quadrature sample.
- dec_valid  output  1  one-clk pulse; I_dec/Q_dec updated in the same cycle.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, all of the following are 0: integrators, comb delay registers, decimation counter cnt, I_dec, Q_dec, dec_valid.
- Integrators:
  - Every clk, stage 1 does int1 += sign-extended input; stage k does intk += int(k-1) registered.
  - Arithmetic is modulo 2^OW. Wrap-around is intended and required; there is no saturation.
- Decimation counter:
  - cnt counts 0..R-1, then wraps to 0. Strobe condition: cnt == R-1.
- On the clk edge where strobe is true:
  - The comb chain is evaluated combinationally from the current intN register value.
  - Each comb computes c_k = x_k - d_k, modulo 2^OW; then d_k <= x_k.
  - The final comb result is registered into I_dec/Q_dec.
  - dec_valid <= 1.
- On all other edges, dec_valid <= 0 and I_dec/Q_dec hold their values.
- Timing:
  - First dec_valid occurs R clks after reset deassertion; subsequent pulses follow every R clks exactly.
  - Input-to-output latency is one clk from the strobe edge. No back-pressure.
- Channels: I and Q are processed identically and independently, sharing one counter, so dec_valid is common to both.
- DC gain is R^N. Full-scale input -2^(IW-1) maps to exactly -2^(OW-1) with no overflow. Output is the full OW width with no truncation.
- Transient: the first N outputs after reset are settling values. From the (N+1)th dec_valid onward, output equals the true CIC response.
- Reset mid-operation: state clears immediately, and any in-progress decimation period is discarded. The next dec_valid occurs R clks after release.

Decomposition:
- Package cic_pkg:
  - Function cic_out_width(IW, N, R).
  - Default constants CIC_N=3, CIC_R=64.
- Sub-module cic_channel:
  - Holds the N integrators and N combs for one channel.
  - Inputs: strobe (from the top-level counter) and x.
  - Output: y (registered) plus its own registers.
- cic_decimator:
  - Owns cnt and dec_valid.
  - Instantiates cic_channel twice (I, Q).

Test Plan:
- Zero input: I=Q=0 for 2000 clks -> I_dec=Q_dec=0 at every dec_valid; dec_valid period exactly 64 clks; first pulse at clk 64 after reset release.
- DC: I=+1, Q=-1 constant -> from 4th dec_valid onward, I_dec=+262144 and Q_dec=-262144.
- Full-scale negative: I=Q=-2 constant -> from 4th dec_valid onward, I_dec=Q_dec=-524288. No overflow artefacts over 20000 clks, which exercises integrator wrap-around.
- Nyquist tone: I alternating +1/-1 every clk, Q=0 -> I_dec=0 from 4th dec_valid onward (R even places a CIC null at fs/2).
- Reset mid-operation: assert reset at clk 150 for 3 clks with I=+1 -> outputs and dec_valid go 0 asynchronously. Next dec_valid occurs 64 clks after release, and the settling sequence repeats identically to the DC test.
- Reference model: random 2-bit I/Q for 50000 clks, compared sample-exact against a bit-true modulo-2^20 CIC model -> zero mismatches.
